// File: rtl/reg_file_param_if.sv
// rtl/reg_file_param_if.sv - bus bundle for the parameterised two-read-port register file
interface reg_file_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              re_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;
  logic              rvalid_a;
  logic              rvalid_b;
  logic              clear;
  logic              busy;

  modport master (
    output we, waddr, wdata, re_a, re_b, raddr_a, raddr_b, clear,
    input  rdata_a, rdata_b, rvalid_a, rvalid_b, busy
  );

  modport slave (
    input  we, waddr, wdata, re_a, re_b, raddr_a, raddr_b, clear,
    output rdata_a, rdata_b, rvalid_a, rvalid_b, busy
  );
endinterface

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - register file, one write and two registered read ports, sweep clear
module reg_file_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  reg_file_param_if.slave   bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              accept;
  logic              sweep_en;
  logic              wr_ok;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_a_val, rd_b_val;
  logic [WIDTH-1:0]  rdata_a, rdata_b;
  logic              rvalid_a, rvalid_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Traffic is only accepted in IDLE on an edge that does not start a sweep.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept    = 1'b0;
    sweep_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
        end else begin
          accept = 1'b1;
        end
      end
      SWEEP: begin
        sweep_en = 1'b1;
        idx_nxt  = idx + 1'b1;
        if (idx == {ADDR_W{1'b1}}) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_ok = accept && bus.we && !(ZERO_REG != 0 && bus.waddr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (sweep_en) begin
      mem[idx] <= '0;
    end else if (wr_ok) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // Zero-register override is applied last so it also masks a bypassed write.
  always_comb begin
    rd_a_val = mem[bus.raddr_a];
    if (BYPASS != 0 && wr_ok && bus.waddr == bus.raddr_a) rd_a_val = bus.wdata;
    if (ZERO_REG != 0 && bus.raddr_a == '0) rd_a_val = '0;
  end

  always_comb begin
    rd_b_val = mem[bus.raddr_b];
    if (BYPASS != 0 && wr_ok && bus.waddr == bus.raddr_b) rd_b_val = bus.wdata;
    if (ZERO_REG != 0 && bus.raddr_b == '0) rd_b_val = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_a  <= '0;
      rdata_b  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= accept && bus.re_a;
      rvalid_b <= accept && bus.re_b;
      if (accept && bus.re_a) rdata_a <= rd_a_val;
      if (accept && bus.re_b) rdata_b <= rd_b_val;
    end
  end

  assign bus.rdata_a  = rdata_a;
  assign bus.rdata_b  = rdata_b;
  assign bus.rvalid_a = rvalid_a;
  assign bus.rvalid_b = rvalid_b;
  assign bus.busy     = (state == SWEEP);
endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - bench for reg_file_param: reference model, directed and random steps
module tb_reg_file_param;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  reg_file_param_if #(.WIDTH(32), .ADDR_W(5)) bus ();
  reg_file_param_if #(.WIDTH(32), .ADDR_W(5)) bus_nb ();
  reg_file_param_if #(.WIDTH(16), .ADDR_W(3)) bus16 ();
  reg_file_param_if #(.WIDTH(64), .ADDR_W(6)) bus64 ();

  reg_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut0 (.clk(clk), .reset(reset), .bus(bus));
  reg_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut1 (.clk(clk), .reset(reset), .bus(bus_nb));
  reg_file_param #(.WIDTH(16), .ADDR_W(3)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  reg_file_param #(.WIDTH(64), .ADDR_W(6)) dut64 (.clk(clk), .reset(reset), .bus(bus64));

  // The plain (no zero register, no bypass) instance sees exactly the same traffic.
  assign bus_nb.we      = bus.we;
  assign bus_nb.waddr   = bus.waddr;
  assign bus_nb.wdata   = bus.wdata;
  assign bus_nb.re_a    = bus.re_a;
  assign bus_nb.re_b    = bus.re_b;
  assign bus_nb.raddr_a = bus.raddr_a;
  assign bus_nb.raddr_b = bus.raddr_b;
  assign bus_nb.clear   = bus.clear;

  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  int          left;
  logic [31:0] e0a, e0b, e1a, e1b;
  bit          eva, evb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    left = 0;
    e0a = '0; e0b = '0; e1a = '0; e1b = '0;
    eva = 1'b0; evb = 1'b0;
  endtask

  function automatic logic [31:0] mval(input bit plain, input int a);
    if (plain) return m1[a];
    if (a == 0) return 32'h0;
    if (bus.we && int'(bus.waddr) == a) return bus.wdata;
    return m0[a];
  endfunction

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic idle();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re_a = 1'b0; bus.re_b = 1'b0; bus.raddr_a = '0; bus.raddr_b = '0;
    bus.clear = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of the 32-entry pair: predict from the current inputs, advance, compare.
  task automatic cycle();
    bit acc;
    acc = (left == 0) && !bus.clear;
    eva = acc && bus.re_a;
    evb = acc && bus.re_b;
    if (eva) begin e0a = mval(0, int'(bus.raddr_a)); e1a = mval(1, int'(bus.raddr_a)); end
    if (evb) begin e0b = mval(0, int'(bus.raddr_b)); e1b = mval(1, int'(bus.raddr_b)); end
    if (left > 0) begin
      m0[32 - left] = '0;
      m1[32 - left] = '0;
      left--;
    end else if (bus.clear) begin
      left = 32;
    end else if (bus.we) begin
      if (bus.waddr != 0) m0[bus.waddr] = bus.wdata;
      m1[bus.waddr] = bus.wdata;
    end
    tick();
    chk("d0_rdata_a", bus.rdata_a, e0a);
    chk("d0_rdata_b", bus.rdata_b, e0b);
    chk("d0_rvalid_a", bus.rvalid_a, eva);
    chk("d0_rvalid_b", bus.rvalid_b, evb);
    chk("d0_busy", bus.busy, left > 0);
    chk("d1_rdata_a", bus_nb.rdata_a, e1a);
    chk("d1_rdata_b", bus_nb.rdata_b, e1b);
    chk("d1_rvalid_a", bus_nb.rvalid_a, eva);
    chk("d1_rvalid_b", bus_nb.rvalid_b, evb);
    chk("d1_busy", bus_nb.busy, left > 0);
  endtask

  initial begin
    int n;
    logic [15:0] d16;
    logic [63:0] d64;

    reset = 1'b1;
    idle();
    bus16.we = 0; bus16.waddr = '0; bus16.wdata = '0; bus16.re_a = 0; bus16.re_b = 0;
    bus16.raddr_a = '0; bus16.raddr_b = '0; bus16.clear = 0;
    bus64.we = 0; bus64.waddr = '0; bus64.wdata = '0; bus64.re_a = 0; bus64.re_b = 0;
    bus64.raddr_a = '0; bus64.raddr_b = '0; bus64.clear = 0;
    model_reset();
    #12;
    chk("rst_rdata_a", bus.rdata_a, 0);
    chk("rst_rvalid_b", bus.rvalid_b, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst16_busy", bus16.busy, 0);
    reset = 1'b0;

    // Write 7, then read it on port A one cycle later.
    bus.we = 1; bus.waddr = 5'd7; bus.wdata = 32'hDEADBEEF;
    cycle();
    idle(); bus.re_a = 1; bus.raddr_a = 5'd7;
    cycle();
    chk("wr7_rdata_a", bus.rdata_a, 32'hDEADBEEF);
    chk("wr7_rvalid_a", bus.rvalid_a, 1);
    idle();
    cycle();
    chk("wr7_rvalid_drop", bus.rvalid_a, 0);
    chk("wr7_rdata_hold", bus.rdata_a, 32'hDEADBEEF);

    // Same-cycle write/read collision on address 3, independent read of 4.
    bus.we = 1; bus.waddr = 5'd4; bus.wdata = 32'hA5A5A5A5; cycle();
    bus.we = 1; bus.waddr = 5'd3; bus.wdata = 32'h11110000; cycle();
    bus.we = 1; bus.waddr = 5'd3; bus.wdata = 32'h12345678;
    bus.re_a = 1; bus.raddr_a = 5'd3; bus.re_b = 1; bus.raddr_b = 5'd4;
    cycle();
    chk("byp1_a", bus.rdata_a, 32'h12345678);
    chk("byp1_b", bus.rdata_b, 32'hA5A5A5A5);
    chk("byp0_a", bus_nb.rdata_a, 32'h11110000);
    chk("byp0_b", bus_nb.rdata_b, 32'hA5A5A5A5);

    // Register zero is hard-wired on the zero-register instance only.
    idle(); bus.we = 1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF; cycle();
    idle(); bus.re_a = 1; bus.re_b = 1; cycle();
    chk("zr_a", bus.rdata_a, 0);
    chk("zr_b", bus.rdata_b, 0);
    chk("nozr_a", bus_nb.rdata_a, 32'hFFFFFFFF);
    idle(); bus.we = 1; bus.waddr = 5'd0; bus.wdata = 32'h5555AAAA;
    bus.re_a = 1; bus.raddr_a = 5'd0; cycle();
    chk("zr_bypass_a", bus.rdata_a, 0);

    // Fill, clear, poke mid-sweep, then read everything back.
    for (int a = 0; a < 32; a++) begin
      idle(); bus.we = 1; bus.waddr = 5'(a); bus.wdata = $urandom | 32'h1; cycle();
    end
    idle(); bus.clear = 1; cycle();
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      idle();
      if (n == 5) begin bus.we = 1; bus.waddr = 5'd30; bus.wdata = 32'hCAFEF00D; bus.re_a = 1; bus.raddr_a = 5'd30; end
      if (n == 7) bus.clear = 1;
      cycle();
    end
    chk("sweep32_len", n, 32);
    for (int a = 0; a < 32; a++) begin
      idle(); bus.re_a = 1; bus.raddr_a = 5'(a); bus.re_b = 1; bus.raddr_b = 5'(31 - a); cycle();
      chk("swept_d0", bus.rdata_a, 0);
      chk("swept_d1", bus_nb.rdata_b, 0);
    end

    // Randomised traffic with occasional clears.
    for (int k = 0; k < 300; k++) begin
      idle();
      bus.we = 1'($urandom_range(0, 1));
      bus.waddr = pick_addr();
      bus.wdata = $urandom;
      bus.re_a = 1'($urandom_range(0, 1));
      bus.raddr_a = pick_addr();
      bus.re_b = 1'($urandom_range(0, 1));
      bus.raddr_b = pick_addr();
      bus.clear = ($urandom_range(0, 49) == 0);
      cycle();
    end
    idle();
    n = 0;
    while (left > 0 && n < 100) begin n++; cycle(); end

    // Asynchronous reset part way through a sweep.
    for (int a = 1; a < 32; a++) begin
      idle(); bus.we = 1; bus.waddr = 5'(a); bus.wdata = 32'h100 + 32'(a); bus.re_a = 1; bus.raddr_a = 5'(a); cycle();
    end
    idle(); bus.clear = 1; cycle();
    idle();
    for (int k = 0; k < 10; k++) cycle();
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_rdata_a", bus.rdata_a, 0);
    chk("arst_rvalid_a", bus.rvalid_a, 0);
    chk("arst_d1_rdata_a", bus_nb.rdata_a, 0);
    model_reset();
    #2 reset = 1'b0;
    bus.we = 1; bus.waddr = 5'd20; bus.wdata = 32'hDEADBEEF; cycle();
    idle(); bus.re_a = 1; bus.raddr_a = 5'd20; bus.re_b = 1; bus.raddr_b = 5'd25; cycle();
    chk("post_rst_rdata_a", bus.rdata_a, 32'hDEADBEEF);
    chk("post_rst_rvalid_a", bus.rvalid_a, 1);
    chk("post_rst_cleared_b", bus.rdata_b, 0);
    idle();

    // 16-bit / 8-entry variant.
    d16 = 16'h8001 | (16'($urandom) & 16'h7FFE);
    bus16.we = 1; bus16.waddr = 3'd5; bus16.wdata = d16; tick();
    bus16.we = 0; bus16.re_a = 1; bus16.raddr_a = 3'd5; bus16.re_b = 1; bus16.raddr_b = 3'd5; tick();
    bus16.re_a = 0; bus16.re_b = 0;
    chk("w16_data", bus16.rdata_a, d16);
    chk("w16_msb", bus16.rdata_a[15], 1);
    chk("w16_lsb", bus16.rdata_b[0], 1);
    bus16.clear = 1; tick(); bus16.clear = 0;
    n = 0;
    while (bus16.busy && n < 200) begin n++; tick(); end
    chk("sweep16_len", n, 8);
    bus16.re_a = 1; tick(); bus16.re_a = 0;
    chk("sweep16_zero", bus16.rdata_a, 0);

    // 64-bit / 64-entry variant.
    d64 = 64'h8000_0000_0000_0001 | ({32'($urandom), 32'($urandom)} & 64'h7FFF_FFFF_FFFF_FFFE);
    bus64.we = 1; bus64.waddr = 6'd63; bus64.wdata = d64; tick();
    bus64.we = 0; bus64.re_a = 1; bus64.raddr_a = 6'd63; tick();
    bus64.re_a = 0;
    chk("w64_data", bus64.rdata_a, d64);
    chk("w64_msb", bus64.rdata_a[63], 1);
    chk("w64_lsb", bus64.rdata_a[0], 1);
    bus64.clear = 1; tick(); bus64.clear = 0;
    n = 0;
    while (bus64.busy && n < 200) begin n++; tick(); end
    chk("sweep64_len", n, 64);
    bus64.re_b = 1; bus64.raddr_b = 6'd63; tick(); bus64.re_b = 0;
    chk("sweep64_zero", bus64.rdata_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
